// File: rtl/intf_pkg.sv
// Shared types and widths for the dut-interface initiator.
package intf_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CFG_W  = 32;

  typedef enum logic [1:0] {
    OP_CFG_RD = 2'd0,
    OP_CFG_WR = 2'd1,
    OP_SEND   = 2'd2,
    OP_NOP    = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_LEN  = 2'd2,
    S_DATA = 2'd3
  } state_e;

  // Saturating increment for the rdy wait counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/intf_rx_fifo.sv
// Receive FIFO for dout bytes; a push is accepted on a full FIFO when a pop frees a slot.
module intf_rx_fifo
  import intf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;
  logic              do_push_s;
  logic              do_pop_s;

  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign data_o    = mem_q[rd_q[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/intf_initiator.sv
// Initiator for the dut din/dout/len/cfg methods: sequences host commands into
// enable/ready handshakes and drains dout into a small receive FIFO.
module intf_initiator
  import intf_pkg::*;
#(
  parameter int RXDEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CFG_W-1:0]  cmd_wdata,
  input  logic [7:0]        cmd_len,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rd_valid,
  output logic [CFG_W-1:0]  rd_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] din_value,
  output logic              din_en,
  input  logic              din_rdy,
  output logic              dout_en,
  input  logic [DATA_W-1:0] dout_value,
  input  logic              dout_rdy,
  output logic [7:0]        len_value,
  output logic              len_en,
  input  logic              len_rdy,
  output logic [ADDR_W-1:0] cfg_address,
  output logic [CFG_W-1:0]  cfg_data_in,
  output logic              cfg_op,
  output logic              cfg_en,
  input  logic [CFG_W-1:0]  cfg_data_out,
  input  logic              cfg_rdy
);

  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

  state_e            state_q, state_d;
  logic [15:0]       wait_q, wait_d;
  logic [7:0]        rem_q, rem_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CFG_W-1:0]  wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [CFG_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;
  logic              cmd_ready_s, stall_s, cfg_en_s, len_en_s, din_en_s;
  logic [15:0]       wait_inc_s;
  logic              fifo_full_s, fifo_empty_s;
  cmd_op_e           op_s;

  assign op_s        = cmd_op_e'(cmd_op);
  assign wait_inc_s  = sat_inc(wait_q);
  assign cmd_ready_s = (state_q == S_IDLE) && !RST;

  // Next-state, handshake enables and timeout.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rem_d      = rem_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    cfg_en_s   = 1'b0;
    len_en_s   = 1'b0;
    din_en_s   = 1'b0;
    stall_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_s) begin
          wait_d  = 16'd0;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          len_d   = cmd_len;
          wr_d    = (op_s == OP_CFG_WR);
          case (op_s)
            OP_CFG_RD, OP_CFG_WR: state_d = S_CFG;
            OP_SEND:              state_d = (cmd_len != 8'd0) ? S_LEN : S_IDLE;
            default:              state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG: begin
        cfg_en_s = cfg_rdy;
        if (cfg_rdy) begin
          state_d = S_IDLE;
          wait_d  = 16'd0;
          if (!wr_q) begin
            rd_data_d  = cfg_data_out;
            rd_valid_d = 1'b1;
          end else begin
            rd_valid_d = 1'b0;
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      S_LEN: begin
        len_en_s = len_rdy;
        if (len_rdy) begin
          state_d = S_DATA;
          rem_d   = len_q;
          wait_d  = 16'd0;
        end else begin
          stall_s = 1'b1;
        end
      end
      S_DATA: begin
        din_en_s = tx_valid && din_rdy;
        if (din_en_s) begin
          rem_d   = rem_q - 8'd1;
          wait_d  = 16'd0;
          state_d = (rem_q == 8'd1) ? S_IDLE : S_DATA;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A stall that reaches the limit abandons the rest of the command.
    if (stall_s) begin
      wait_d = wait_inc_s;
      if (TO_EN && ({16'd0, wait_inc_s} >= TO_LIM)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        err_d = err_q;
      end
    end else begin
      err_d = err_q;
    end
  end

  // State and command registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wait_q     <= 16'd0;
      rem_q      <= 8'd0;
      len_q      <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  intf_rx_fifo #(.DEPTH(RXDEPTH)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (dout_en),
    .data_i  (dout_value),
    .pop_i   (rx_ready),
    .data_o  (rx_data),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign cmd_ready   = cmd_ready_s;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign cfg_en      = cfg_en_s;
  assign cfg_op      = wr_q;
  assign cfg_address = addr_q;
  assign cfg_data_in = wdata_q;
  assign len_en      = len_en_s;
  assign len_value   = len_q;
  assign din_en      = din_en_s;
  assign tx_ready    = din_en_s;
  assign din_value   = (state_q == S_DATA) ? tx_data : '0;
  assign rx_valid    = !fifo_empty_s;
  assign dout_en     = dout_rdy && !RST && (!fifo_full_s || rx_ready);

endmodule

// File: tb/tb_intf_initiator.sv
// Directed self-checking bench for intf_initiator (RXDEPTH=4, TIMEOUT=5).
module tb_intf_initiator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr, cmd_len;
  logic [31:0] cmd_wdata;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        busy, err;
  logic [7:0]  din_value;
  logic        din_en, din_rdy;
  logic        dout_en, dout_rdy;
  logic [7:0]  dout_value;
  logic [7:0]  len_value;
  logic        len_en, len_rdy;
  logic [7:0]  cfg_address;
  logic [31:0] cfg_data_in, cfg_data_out;
  logic        cfg_op, cfg_en, cfg_rdy;

  int checks = 0;
  int failures = 0;

  intf_initiator #(.RXDEPTH(4), .TIMEOUT(5)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .busy(busy), .err(err),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a,
                       input logic [31:0] d, input logic [7:0] l);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_len = l;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 8'd0; cmd_wdata = 32'd0; cmd_len = 8'd0;
    tx_valid = 1'b0; tx_data = 8'd0; rx_ready = 1'b0;
    din_rdy = 1'b0; dout_rdy = 1'b0; dout_value = 8'd0; len_rdy = 1'b0;
    cfg_rdy = 1'b0; cfg_data_out = 32'd0;
    #2;
    checks++;
    if ({cmd_ready, busy, err, rd_valid, rx_valid, din_en, dout_en, len_en, cfg_en, tx_ready} !== 10'd0) begin
      $display("FAIL reset_flags got=%b want=0", {cmd_ready, busy, err, rd_valid, rx_valid, din_en, dout_en, len_en, cfg_en, tx_ready});
      failures++;
    end
    checks++;
    if ({rd_data, cfg_data_in, cfg_address, len_value, din_value} !== 64'd0) begin
      $display("FAIL reset_values got=%h want=0", {rd_data, cfg_data_in, cfg_address, len_value, din_value});
      failures++;
    end
    cyc(); cyc();
    RST = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL reset_release_cmd_ready got=%b want=1", cmd_ready);
      failures++;
    end
  endtask

  task automatic test_cfg_wr();
    int en_cnt = 0;
    int en_cyc = -1;
    int rdv_cnt = 0;
    cfg_rdy = 1'b0;
    issue(2'd1, 8'h04, 32'hDEADBEEF, 8'd0);
    for (int i = 0; i < 6; i++) begin
      cfg_rdy = (i >= 3);
      #1;
      if (cfg_en) begin
        en_cnt++; en_cyc = i;
        checks++;
        if ({cfg_op, cfg_address, cfg_data_in} !== {1'b1, 8'h04, 32'hDEADBEEF}) begin
          $display("FAIL cfgwr_fields got=%h want=%h", {cfg_op, cfg_address, cfg_data_in}, {1'b1, 8'h04, 32'hDEADBEEF});
          failures++;
        end
      end
      if (rd_valid) rdv_cnt++;
      if (i == 4) begin
        checks++;
        if (busy !== 1'b0) begin
          $display("FAIL cfgwr_busy_drop got=%b want=0", busy);
          failures++;
        end
      end
      cyc();
    end
    checks++;
    if (en_cnt != 1 || en_cyc != 3) begin
      $display("FAIL cfgwr_en got=%0d@%0d want=1@3", en_cnt, en_cyc);
      failures++;
    end
    checks++;
    if (rdv_cnt != 0) begin
      $display("FAIL cfgwr_no_rd_valid got=%0d want=0", rdv_cnt);
      failures++;
    end
  endtask

  task automatic test_cfg_rd();
    int rdv_cnt = 0;
    logic [31:0] seen = 32'd0;
    cfg_rdy = 1'b1;
    cfg_data_out = 32'h12345678;
    issue(2'd0, 8'h08, 32'h0, 8'd0);
    #1;
    checks++;
    if ({cfg_en, cfg_op, cfg_address} !== {1'b1, 1'b0, 8'h08}) begin
      $display("FAIL cfgrd_req got=%h want=%h", {cfg_en, cfg_op, cfg_address}, {1'b1, 1'b0, 8'h08});
      failures++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      cfg_data_out = 32'hCAFEF00D;
      if (rd_valid) begin rdv_cnt++; seen = rd_data; end
    end
    checks++;
    if (rdv_cnt != 1 || seen !== 32'h12345678) begin
      $display("FAIL cfgrd_result got=%0d/%h want=1/12345678", rdv_cnt, seen);
      failures++;
    end
    cfg_rdy = 1'b0;
  endtask

  task automatic test_send3();
    logic [7:0] payload [3];
    int sent = 0;
    int len_cnt = 0;
    payload[0] = 8'hA1; payload[1] = 8'hA2; payload[2] = 8'hA3;
    len_rdy = 1'b1;
    issue(2'd2, 8'h00, 32'h0, 8'd3);
    for (int i = 0; i < 14; i++) begin
      tx_valid = (i % 3 != 1);
      din_rdy  = (i % 2 == 0) || (i % 5 == 4);
      tx_data  = (sent < 3) ? payload[sent] : 8'h00;
      #1;
      if (len_en) begin
        len_cnt++;
        checks++;
        if (len_value !== 8'd3) begin
          $display("FAIL send3_len_value got=%h want=03", len_value);
          failures++;
        end
      end
      if (din_en) begin
        checks++;
        if (sent >= 3 || din_value !== payload[sent] || tx_ready !== 1'b1) begin
          $display("FAIL send3_din idx=%0d got=%h want=%h", sent, din_value, (sent < 3) ? payload[sent] : 8'hxx);
          failures++;
        end
        sent++;
      end
      cyc();
    end
    checks++;
    if (len_cnt != 1 || sent != 3 || busy !== 1'b0) begin
      $display("FAIL send3_counts got=len%0d din%0d busy%b want=len1 din3 busy0", len_cnt, sent, busy);
      failures++;
    end
    tx_valid = 1'b0; din_rdy = 1'b0; len_rdy = 1'b0;
  endtask

  task automatic test_send0();
    int en_cnt = 0;
    issue(2'd2, 8'h00, 32'h0, 8'd0);
    #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      $display("FAIL send0_ready got=%b want=10", {cmd_ready, busy});
      failures++;
    end
    len_rdy = 1'b1; din_rdy = 1'b1; tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (len_en || din_en) en_cnt++;
      cyc();
    end
    checks++;
    if (en_cnt != 0) begin
      $display("FAIL send0_no_en got=%0d want=0", en_cnt);
      failures++;
    end
    len_rdy = 1'b0; din_rdy = 1'b0; tx_valid = 1'b0;
  endtask

  task automatic test_rx();
    logic [7:0] exp_q [6];
    int pushes = 0;
    exp_q[0] = 8'h10; exp_q[1] = 8'h11; exp_q[2] = 8'h12;
    exp_q[3] = 8'h13; exp_q[4] = 8'h20; exp_q[5] = 8'h21;
    dout_rdy = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dout_value = 8'h10 + 8'(i);
      #1;
      if (dout_en) pushes++;
      cyc();
    end
    checks++;
    if (pushes != 4) begin
      $display("FAIL rx_fill_count got=%0d want=4", pushes);
      failures++;
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dout_value = 8'h20 + 8'(i);
      #1;
      checks++;
      if ({dout_en, rx_valid, rx_data} !== {2'b11, exp_q[i]}) begin
        $display("FAIL rx_full_pushpop i=%0d got=%h want=%h", i, {dout_en, rx_valid, rx_data}, {2'b11, exp_q[i]});
        failures++;
      end
      cyc();
    end
    dout_rdy = 1'b0;
    for (int i = 2; i < 6; i++) begin
      #1;
      checks++;
      if ({rx_valid, rx_data} !== {1'b1, exp_q[i]}) begin
        $display("FAIL rx_drain i=%0d got=%h want=%h", i, {rx_valid, rx_data}, {1'b1, exp_q[i]});
        failures++;
      end
      cyc();
    end
    cyc();
    checks++;
    if (rx_valid !== 1'b0) begin
      $display("FAIL rx_empty got=%b want=0", rx_valid);
      failures++;
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_timeout_rst();
    int din_cnt = 0;
    din_rdy = 1'b0; len_rdy = 1'b1; tx_valid = 1'b1; tx_data = 8'h55;
    issue(2'd2, 8'h00, 32'h0, 8'd2);
    cyc();
    for (int k = 1; k <= 5; k++) begin
      if (din_en) din_cnt++;
      cyc();
      if (k == 4) begin
        checks++;
        if ({err, busy} !== 2'b01) begin
          $display("FAIL timeout_before got=%b want=01", {err, busy});
          failures++;
        end
      end
    end
    checks++;
    if ({err, busy, cmd_ready} !== 3'b101 || din_cnt != 0) begin
      $display("FAIL timeout_after got=%b din=%0d want=101 din=0", {err, busy, cmd_ready}, din_cnt);
      failures++;
    end
    din_rdy = 1'b1; dout_rdy = 1'b1; cfg_rdy = 1'b1;
    issue(2'd2, 8'h00, 32'h0, 8'd2);
    cyc();
    checks++;
    if (din_en !== 1'b1) begin
      $display("FAIL rst_pre_din got=%b want=1", din_en);
      failures++;
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({din_en, len_en, cfg_en, tx_ready, dout_en, busy, err, cmd_ready} !== 8'd0) begin
      $display("FAIL rst_async_drop got=%b want=0", {din_en, len_en, cfg_en, tx_ready, dout_en, busy, err, cmd_ready});
      failures++;
    end
    cyc(); cyc();
    dout_rdy = 1'b0;
    RST = 1'b0;
    din_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (din_en || len_en || cfg_en) din_cnt++;
      cyc();
    end
    checks++;
    if (din_cnt != 0 || cmd_ready !== 1'b1) begin
      $display("FAIL rst_after_idle got=en%0d ready%b want=en0 ready1", din_cnt, cmd_ready);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_cfg_wr();
    test_cfg_rd();
    test_send3();
    test_send0();
    test_rx();
    test_timeout_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
